// File: rtl/ifetch_unit.sv
// Instruction fetch sequencer: steps the PC counter, assembles 16/32-bit
// instructions from halfword memory and presents them through a valid/ready register.
//
// state  | meaning
// BOOT   | first cycle after reset; counter wraps from all-ones to 0
// FETCH  | decoding the halfword at pc_in as a short instr or a long hi
// FETCH2 | hi captured; pc_in now points at the long instr's low half
module ifetch_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [15:0]       mem_data,
  output logic              pc_en,
  output logic              pc_dir,
  output logic              pc_jmp,
  output logic [ADDR_W-1:0] pc_jmp_loc,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  typedef enum logic [1:0] {BOOT, FETCH, FETCH2} state_t;

  state_t            state_q, state_d;
  logic [31:0]       instr_out_q, instr_out_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic [15:0]       hi_reg_q, hi_reg_d;
  logic [ADDR_W-1:0] hi_pc_q, hi_pc_d;
  logic              slot_free;

  assign slot_free   = !instr_valid_q || instr_ready;
  assign pc_dir      = 1'b1;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      hi_reg_q      <= '0;
      hi_pc_q       <= '0;
    end else begin
      state_q       <= state_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      hi_reg_q      <= hi_reg_d;
      hi_pc_q       <= hi_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q && !instr_ready;
    hi_reg_d      = hi_reg_q;
    hi_pc_d       = hi_pc_q;
    pc_en         = 1'b0;
    pc_jmp        = 1'b0;
    pc_jmp_loc    = '0;

    // Counter controls stay quiet while reset is held, even if redirect is high.
    if (!rst) begin
      if (redirect) begin
        pc_en         = 1'b1;
        pc_jmp        = 1'b1;
        pc_jmp_loc    = redirect_addr;
        instr_valid_d = 1'b0;
        state_d       = FETCH;
      end else if (!stall) begin
        case (state_q)
          BOOT: begin
            pc_en   = 1'b1;
            state_d = FETCH;
          end
          FETCH: begin
            // A long hi is captured even under backpressure; the wait happens in FETCH2.
            if (mem_data[15]) begin
              hi_reg_d = mem_data;
              hi_pc_d  = pc_in;
              pc_en    = 1'b1;
              state_d  = FETCH2;
            end else if (slot_free) begin
              instr_out_d   = {16'h0000, mem_data};
              instr_pc_d    = pc_in;
              instr_valid_d = 1'b1;
              pc_en         = 1'b1;
            end
          end
          FETCH2: begin
            if (slot_free) begin
              instr_out_d   = {hi_reg_q, mem_data};
              instr_pc_d    = hi_pc_q;
              instr_valid_d = 1'b1;
              pc_en         = 1'b1;
              state_d       = FETCH;
            end
          end
          default: state_d = BOOT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: behavioural PC counter and instruction memory, directed
// scenarios plus a randomized run against an instruction-stream parsing model.
module tb_ifetch_unit;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc_in;
  logic [15:0]   mem_data;
  logic          pc_en, pc_dir, pc_jmp;
  logic [AW-1:0] pc_jmp_loc;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic [31:0]   instr_out;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b1;

  logic [15:0]   mem [0:1023];
  logic [AW-1:0] pc_q;
  int checks = 0;
  int failures = 0;

  ifetch_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .mem_data(mem_data),
    .pc_en(pc_en), .pc_dir(pc_dir), .pc_jmp(pc_jmp), .pc_jmp_loc(pc_jmp_loc),
    .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  // PC counter: resets to all-ones, loads on jump, else steps by direction.
  always @(posedge clk or posedge rst) begin
    if (rst) pc_q <= '1;
    else if (pc_en) pc_q <= pc_jmp ? pc_jmp_loc : (pc_dir ? pc_q + 1'b1 : pc_q - 1'b1);
  end
  assign pc_in    = pc_q;
  assign mem_data = mem[pc_in];

  task automatic go();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b1; redirect_addr = 10'h155; instr_ready = 1'b1;
    go(); smp();
    checks++;
    if ({instr_valid, instr_out, instr_pc} !== {1'b0, 32'h0, 10'h0}) begin
      failures++; $display("FAIL reset_regs got=%h exp=%h", {instr_valid, instr_out, instr_pc}, {1'b0, 32'h0, 10'h0});
    end
    checks++;
    if ({pc_en, pc_jmp, pc_dir, pc_jmp_loc} !== {1'b0, 1'b0, 1'b1, 10'h0}) begin
      failures++; $display("FAIL reset_ctrl got=%h exp=%h", {pc_en, pc_jmp, pc_dir, pc_jmp_loc}, {1'b0, 1'b0, 1'b1, 10'h0});
    end
    redirect = 1'b0;
  endtask

  task automatic test_boot_short_long();
    logic [31:0]   e_out [0:4];
    logic [AW-1:0] e_pc  [0:4];
    logic          e_v   [0:4];
    clear_mem();
    mem[0] = 16'h1234; mem[1] = 16'h0042; mem[2] = 16'h7FFF; mem[3] = 16'h8ABC; mem[4] = 16'h5678;
    e_v[0] = 1; e_out[0] = 32'h00001234; e_pc[0] = 10'd0;
    e_v[1] = 1; e_out[1] = 32'h00000042; e_pc[1] = 10'd1;
    e_v[2] = 1; e_out[2] = 32'h00007FFF; e_pc[2] = 10'd2;
    e_v[3] = 0; e_out[3] = 32'h00007FFF; e_pc[3] = 10'd2;
    e_v[4] = 1; e_out[4] = 32'h8ABC5678; e_pc[4] = 10'd3;
    instr_ready = 1'b1;
    do_reset();
    smp();
    checks++;
    if ({pc_in, pc_en, pc_jmp, instr_valid} !== {10'h3FF, 1'b1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL boot_cycle got=%h exp=%h", {pc_in, pc_en, pc_jmp, instr_valid}, {10'h3FF, 1'b1, 1'b0, 1'b0});
    end
    go(); smp();
    checks++;
    if ({pc_in, instr_valid} !== {10'h000, 1'b0}) begin
      failures++; $display("FAIL boot_addr0 got=%h exp=%h", {pc_in, instr_valid}, {10'h000, 1'b0});
    end
    for (int c = 0; c < 5; c++) begin
      go(); smp();
      checks++;
      if (instr_valid !== e_v[c] || (e_v[c] && {instr_out, instr_pc} !== {e_out[c], e_pc[c]})) begin
        failures++;
        $display("FAIL boot_seq[%0d] got v=%b out=%h pc=%h exp v=%b out=%h pc=%h",
                 c, instr_valid, instr_out, instr_pc, e_v[c], e_out[c], e_pc[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_mem();
    mem[0] = 16'h0011; mem[1] = 16'h0022; mem[2] = 16'h8033; mem[3] = 16'h0044; mem[4] = 16'h0055;
    instr_ready = 1'b1;
    do_reset();
    go(); go(); smp();
    checks++;
    if ({instr_valid, instr_out} !== {1'b1, 32'h00000011}) begin
      failures++; $display("FAIL bp_first got=%h exp=%h", {instr_valid, instr_out}, {1'b1, 32'h00000011});
    end
    go(); instr_ready = 1'b0; smp();
    checks++;
    if ({instr_valid, instr_out, pc_in, pc_en} !== {1'b1, 32'h00000022, 10'd2, 1'b1}) begin
      failures++; $display("FAIL bp_hi_capture got=%h exp=%h", {instr_valid, instr_out, pc_in, pc_en}, {1'b1, 32'h00000022, 10'd2, 1'b1});
    end
    for (int c = 0; c < 2; c++) begin
      go(); smp();
      checks++;
      if ({instr_valid, instr_out, instr_pc, pc_in, pc_en} !== {1'b1, 32'h00000022, 10'd1, 10'd3, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=%h exp=%h", c, {instr_valid, instr_out, instr_pc, pc_in, pc_en},
                 {1'b1, 32'h00000022, 10'd1, 10'd3, 1'b0});
      end
    end
    go(); instr_ready = 1'b1; smp();
    checks++;
    if ({instr_valid, instr_out, pc_en} !== {1'b1, 32'h00000022, 1'b1}) begin
      failures++; $display("FAIL bp_release got=%h exp=%h", {instr_valid, instr_out, pc_en}, {1'b1, 32'h00000022, 1'b1});
    end
    go(); smp();
    checks++;
    if ({instr_valid, instr_out, instr_pc} !== {1'b1, 32'h80330044, 10'd2}) begin
      failures++; $display("FAIL bp_long got=%h exp=%h", {instr_valid, instr_out, instr_pc}, {1'b1, 32'h80330044, 10'd2});
    end
    go(); smp();
    checks++;
    if ({instr_valid, instr_out, instr_pc} !== {1'b1, 32'h00000055, 10'd4}) begin
      failures++; $display("FAIL bp_after got=%h exp=%h", {instr_valid, instr_out, instr_pc}, {1'b1, 32'h00000055, 10'd4});
    end
  endtask

  task automatic test_redirect_mid_long();
    clear_mem();
    mem[0] = 16'h8111; mem[1] = 16'h0222; mem[10'h020] = 16'h0333;
    instr_ready = 1'b1;
    do_reset();
    go(); go();
    redirect = 1'b1; redirect_addr = 10'h020;
    smp();
    checks++;
    if ({pc_en, pc_jmp, pc_jmp_loc, pc_in} !== {1'b1, 1'b1, 10'h020, 10'd1}) begin
      failures++; $display("FAIL redir_ctrl got=%h exp=%h", {pc_en, pc_jmp, pc_jmp_loc, pc_in}, {1'b1, 1'b1, 10'h020, 10'd1});
    end
    go(); redirect = 1'b0; smp();
    checks++;
    if ({instr_valid, pc_in} !== {1'b0, 10'h020}) begin
      failures++; $display("FAIL redir_flush got=%h exp=%h", {instr_valid, pc_in}, {1'b0, 10'h020});
    end
    go(); smp();
    checks++;
    if ({instr_valid, instr_out, instr_pc} !== {1'b1, 32'h00000333, 10'h020}) begin
      failures++; $display("FAIL redir_target got=%h exp=%h", {instr_valid, instr_out, instr_pc}, {1'b1, 32'h00000333, 10'h020});
    end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[10'h3FF] = 16'hC001; mem[0] = 16'h0002; mem[1] = 16'h0003;
    instr_ready = 1'b1;
    do_reset();
    go(); redirect = 1'b1; redirect_addr = 10'h3FF;
    go(); redirect = 1'b0; smp();
    checks++;
    if ({instr_valid, pc_in} !== {1'b0, 10'h3FF}) begin
      failures++; $display("FAIL wrap_jump got=%h exp=%h", {instr_valid, pc_in}, {1'b0, 10'h3FF});
    end
    go(); go(); smp();
    checks++;
    if ({instr_valid, instr_out, instr_pc} !== {1'b1, 32'hC0010002, 10'h3FF}) begin
      failures++; $display("FAIL wrap_long got=%h exp=%h", {instr_valid, instr_out, instr_pc}, {1'b1, 32'hC0010002, 10'h3FF});
    end
    go(); smp();
    checks++;
    if ({instr_valid, instr_out, instr_pc} !== {1'b1, 32'h00000003, 10'd1}) begin
      failures++; $display("FAIL wrap_next got=%h exp=%h", {instr_valid, instr_out, instr_pc}, {1'b1, 32'h00000003, 10'd1});
    end
  endtask

  task automatic test_stall_reset();
    clear_mem();
    mem[0] = 16'h0101; mem[1] = 16'h0202; mem[2] = 16'h0303; mem[10'h010] = 16'h0777;
    instr_ready = 1'b1;
    do_reset();
    go(); go(); stall = 1'b1; smp();
    checks++;
    if ({instr_valid, instr_out, pc_en} !== {1'b1, 32'h00000101, 1'b0}) begin
      failures++; $display("FAIL stall_c0 got=%h exp=%h", {instr_valid, instr_out, pc_en}, {1'b1, 32'h00000101, 1'b0});
    end
    go(); smp();
    checks++;
    if ({instr_valid, pc_in, pc_en} !== {1'b0, 10'd1, 1'b0}) begin
      failures++; $display("FAIL stall_c1 got=%h exp=%h", {instr_valid, pc_in, pc_en}, {1'b0, 10'd1, 1'b0});
    end
    go(); stall = 1'b0; smp();
    checks++;
    if ({pc_in, pc_en} !== {10'd1, 1'b1}) begin
      failures++; $display("FAIL stall_resume got=%h exp=%h", {pc_in, pc_en}, {10'd1, 1'b1});
    end
    go(); stall = 1'b1; redirect = 1'b1; redirect_addr = 10'h010; smp();
    checks++;
    if ({instr_out, instr_pc, pc_en, pc_jmp, pc_jmp_loc} !== {32'h00000202, 10'd1, 1'b1, 1'b1, 10'h010}) begin
      failures++; $display("FAIL stall_redir got=%h exp=%h", {instr_out, instr_pc, pc_en, pc_jmp, pc_jmp_loc},
                           {32'h00000202, 10'd1, 1'b1, 1'b1, 10'h010});
    end
    go(); stall = 1'b0; redirect = 1'b0; smp();
    checks++;
    if ({instr_valid, pc_in} !== {1'b0, 10'h010}) begin
      failures++; $display("FAIL stall_redir_flush got=%h exp=%h", {instr_valid, pc_in}, {1'b0, 10'h010});
    end
    go(); smp();
    checks++;
    if ({instr_valid, instr_out, instr_pc} !== {1'b1, 32'h00000777, 10'h010}) begin
      failures++; $display("FAIL stall_redir_tgt got=%h exp=%h", {instr_valid, instr_out, instr_pc}, {1'b1, 32'h00000777, 10'h010});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({instr_valid, pc_en} !== {1'b0, 1'b0}) begin
      failures++; $display("FAIL async_rst got=%h exp=%h", {instr_valid, pc_en}, {1'b0, 1'b0});
    end
    @(posedge clk); #1 rst = 1'b0;
    smp();
    checks++;
    if ({pc_in, pc_en, instr_valid} !== {10'h3FF, 1'b1, 1'b0}) begin
      failures++; $display("FAIL rst_reboot got=%h exp=%h", {pc_in, pc_en, instr_valid}, {10'h3FF, 1'b1, 1'b0});
    end
    go(); go(); smp();
    checks++;
    if ({instr_valid, instr_out, instr_pc} !== {1'b1, 32'h00000101, 10'd0}) begin
      failures++; $display("FAIL rst_refetch got=%h exp=%h", {instr_valid, instr_out, instr_pc}, {1'b1, 32'h00000101, 10'd0});
    end
  endtask

  // Random traffic: the model parses memory as an instruction stream from the
  // current start address, restarting at every redirect target.
  task automatic test_random();
    logic [AW-1:0] exp_addr;
    logic [15:0]   hw;
    logic [31:0]   e_out, hold_out;
    logic [AW-1:0] hold_pc;
    logic          hold;
    int            ntx;
    for (int i = 0; i < 1024; i++) begin
      hw = 16'($urandom);
      if ($urandom_range(0, 9) >= 3) hw[15] = 1'b0;
      mem[i] = hw;
    end
    exp_addr = '0; hold = 1'b0; hold_out = '0; hold_pc = '0; ntx = 0;
    instr_ready = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      stall       = ($urandom_range(0, 9) < 2);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_addr = ($urandom_range(0, 3) == 0) ? 10'h3FF - AW'($urandom_range(0, 1)) : AW'($urandom);
      smp();
      checks++;
      if (pc_dir !== 1'b1 || (!pc_jmp && pc_jmp_loc !== '0)) begin
        failures++; $display("FAIL rnd_ctrl cyc=%0d got dir=%b jmp=%b loc=%h", cyc, pc_dir, pc_jmp, pc_jmp_loc);
      end
      if (redirect) begin
        checks++;
        if ({pc_en, pc_jmp, pc_jmp_loc} !== {1'b1, 1'b1, redirect_addr}) begin
          failures++; $display("FAIL rnd_redir cyc=%0d got=%h exp=%h", cyc, {pc_en, pc_jmp, pc_jmp_loc}, {1'b1, 1'b1, redirect_addr});
        end
      end else if (stall) begin
        checks++;
        if (pc_en !== 1'b0) begin
          failures++; $display("FAIL rnd_stall cyc=%0d got pc_en=%b exp=0", cyc, pc_en);
        end
      end
      if (hold) begin
        checks++;
        if ({instr_valid, instr_out, instr_pc} !== {1'b1, hold_out, hold_pc}) begin
          failures++; $display("FAIL rnd_stable cyc=%0d got=%h exp=%h", cyc, {instr_valid, instr_out, instr_pc}, {1'b1, hold_out, hold_pc});
        end
      end
      if (instr_valid && instr_ready && !redirect) begin
        hw = mem[exp_addr];
        e_out = hw[15] ? {hw, mem[exp_addr + 1'b1]} : {16'h0000, hw};
        checks++;
        if ({instr_out, instr_pc} !== {e_out, exp_addr}) begin
          failures++; $display("FAIL rnd_instr cyc=%0d got out=%h pc=%h exp out=%h pc=%h", cyc, instr_out, instr_pc, e_out, exp_addr);
        end
        exp_addr = exp_addr + (hw[15] ? 10'd2 : 10'd1);
        ntx++;
      end
      if (redirect) exp_addr = redirect_addr;
      hold = instr_valid && !instr_ready && !redirect;
      hold_out = instr_out; hold_pc = instr_pc;
      go();
    end
    stall = 1'b0; redirect = 1'b0;
    checks++;
    if (ntx < 500) begin
      failures++; $display("FAIL rnd_progress got=%0d transfers exp>=500", ntx);
    end
  endtask

  initial begin
    test_reset();
    test_boot_short_long();
    test_backpressure();
    test_redirect_mid_long();
    test_wrap();
    test_stall_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch sequencer that drives the program-counter `ctr` instance and consumes the halfwords read from instruction memory at that counter's address. It steps the counter, assembles 16-bit and 32-bit instructions from the 16-bit instruction memory, and presents them to decode through a valid/ready output register. It also applies branch/jump redirects by loading the counter. It sits between the PC counter / instruction memory pair and the decode stage.

## Interface
- `ADDR_W`, 10, PC/instruction-memory address width; equals the counter `width`.
- `clk`  in  1  rising-edge clock, shared with the PC counter.
- `rst`  in  1  asynchronous, active-high reset; also routed to the PC counter.
- `pc_in`  in  ADDR_W  current PC counter output.
- `mem_data`  in  16  instruction-memory halfword at `pc_in`; combinational, valid in the same cycle.
- `pc_en`  out  1  PC counter enable.
- `pc_dir`  out  1  PC counter direction; tied to 1 (increment).
- `pc_jmp`  out  1  PC counter load strobe.
- `pc_jmp_loc`  out  ADDR_W  PC counter load value.
- `stall`  in  1  freeze fetch; the PC does not advance.
- `redirect`  in  1  branch/jump taken this cycle.
- `redirect_addr`  in  ADDR_W  redirect target.
- `instr_out`  out  32  assembled instruction.
- `instr_pc`  out  ADDR_W  address of the instruction's first halfword.
- `instr_valid`  out  1  `instr_out` / `instr_pc` hold a valid instruction.
- `instr_ready`  in  1  decode accepts the instruction this cycle.

## Operation
- **Instruction format:** a halfword with bit 15 = 0 is a short instruction, and `instr_out` = {16'h0000, hw}. A halfword with bit 15 = 1 is the high half of a long instruction. The next sequential halfword is the low half, and `instr_out` = {hi, lo}.
- **Slot free:** `instr_valid`==0 or `instr_ready`==1. A transfer occurs when `instr_valid` and `instr_ready` are both 1.
- **FSM states:** BOOT, FETCH, FETCH2.
- **BOOT:** entered on reset. After reset the counter reads all-ones. In BOOT, `pc_en`=1 with no jump, so the counter wraps to 0. Next state is FETCH.
- **FETCH, short halfword:** if the slot is free, load `instr_out`/`instr_pc` (= `pc_in`), set `instr_valid`=1, and set `pc_en`=1. If the slot is not free, `pc_en`=0 and the state holds.
- **FETCH, long halfword:** capture `hi_reg`=`mem_data` and `hi_pc`=`pc_in` unconditionally, set `pc_en`=1, and go to FETCH2.
- **FETCH2:** if the slot is free, load {`hi_reg`, `mem_data`} with `instr_pc`=`hi_pc`, set `instr_valid`=1, set `pc_en`=1, and go to FETCH. Otherwise `pc_en`=0 and the state holds.
- **Valid clear:** when a transfer occurs and no new load happens, `instr_valid` goes to 0.
- **stall:** forces `pc_en`=0 and the state holds. A transfer still clears `instr_valid`.
- **redirect:** highest priority after reset, from any state including BOOT.
  - Drives `pc_en`=1, `pc_jmp`=1, `pc_jmp_loc`=`redirect_addr`.
  - Next cycle: `instr_valid`=0, the partial `hi_reg` is discarded, and the state is FETCH.
  - It overrides `stall`.
  - An instruction presented in the same cycle is dropped even if `instr_ready`=1; decode must ignore it.
- **Wrap-around:** the PC wraps from 2^ADDR_W-1 to 0. A long instruction straddling the wrap is legal, and `instr_pc`=2^ADDR_W-1.
- **When `pc_jmp`=0:** `pc_jmp_loc` = 0.
- **Output stability:** `instr_out` and `instr_pc` remain stable while `instr_valid`=1 and `instr_ready`=0.

## Timing
- **Reset values:** `instr_valid`=0, `instr_out`=0, `instr_pc`=0, `hi_reg`=0, `hi_pc`=0, state BOOT.
- **Counter controls during reset:** `pc_en`=0 and `pc_jmp`=0 while `rst`=1. `pc_dir`=1 always.
- **Asynchronous reset:** asserting `rst` between edges clears the outputs immediately.
- **Combinational controls:** `pc_en`, `pc_jmp` and `pc_jmp_loc` are combinational from state and inputs; the counter samples them on the same edge.
- **Latency:**
  - A short instruction whose halfword appears on `mem_data` in cycle n is valid from cycle n+1.
  - A long instruction with hi in cycle n and lo in cycle n+1 is valid from cycle n+2.
  - First instruction after reset release: BOOT cycle, address 0 in the next cycle, valid in the cycle after that.
- **Throughput:** one halfword per cycle with no backpressure. Short instructions issue back-to-back; a long instruction leaves a one-cycle gap on `instr_valid`.
- **Redirect:** `redirect` in cycle n gives `pc_in`=`redirect_addr` in n+1 and the target instruction valid in n+2 (if short).

## Test plan
- **Boot and short instructions:** mem[0..2]=16'h1234, 16'h0042, 16'h7FFF; `instr_ready`=1. Required: one BOOT cycle, then `instr_out` = 32'h00001234 / 32'h00000042 / 32'h00007FFF with `instr_pc` 0 / 1 / 2 on consecutive cycles.
- **Long instruction:** mem[3]=16'h8ABC, mem[4]=16'h5678. Required: `instr_out`=32'h8ABC5678, `instr_pc`=3, with a one-cycle `instr_valid` gap before it.
- **Backpressure:** `instr_ready`=0 for 3 cycles with a short instruction pending. Required:
  - `instr_out` is held;
  - `pc_en`=0 once the next instruction is ready to complete;
  - a long hi is captured exactly once;
  - on release, instructions resume in order with none lost or duplicated.
- **Redirect mid-long:** `redirect`=1 with `redirect_addr`=10'h020 while in FETCH2. Required: `pc_jmp`=1 and `pc_jmp_loc`=10'h020 that cycle; the next cycle has `instr_valid`=0; the next instruction has `instr_pc`=10'h020; the partial hi is never emitted.
- **Wrap-around:** redirect to 10'h3FF with mem[3FF]=16'hC001 and mem[000]=16'h0002. Required: `instr_out`=32'hC0010002 and `instr_pc`=10'h3FF.
- **Stall and reset mid-operation:**
  - `stall`=1 for 2 cycles: `pc_en`=0 and the state is unchanged.
  - `stall`+`redirect` together: the redirect wins.
  - Async `rst` asserted mid-cycle: `instr_valid` drops to 0 immediately.
  - After release, fetch restarts from address 0 via BOOT.
